// File: rtl/rv32_regfile_if.sv
// Bus bundle for the RV32I register file: one write port and two combinational read ports.
// The master (pipeline) drives indices/write data; the slave (register file) returns read data.
interface rv32_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we_i;
  logic [ADDR_W-1:0] waddr_i;
  logic [DATA_W-1:0] wdata_i;
  logic [ADDR_W-1:0] raddr1_i;
  logic [DATA_W-1:0] rdata1_o;
  logic [ADDR_W-1:0] raddr2_i;
  logic [DATA_W-1:0] rdata2_o;

  modport master (
    output we_i, waddr_i, wdata_i, raddr1_i, raddr2_i,
    input  rdata1_o, rdata2_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i, raddr1_i, raddr2_i,
    output rdata1_o, rdata2_o
  );
endinterface

// File: rtl/rv32_regfile.sv
// RV32I integer register file: 2**ADDR_W x DATA_W registers, x0 hardwired to zero,
// two combinational read ports with optional same-cycle forwarding of the in-flight write.
module rv32_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input logic           clk,
  input logic           rst,
  rv32_regfile_if.slave rf
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_valid;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;

  // A write only counts when out of reset and not aimed at x0; shared by storage and bypass.
  assign wr_valid = rst && rf.we_i && (rf.waddr_i != '0);

  // NOTE: the register array is reset explicitly because every register must read zero after
  // reset; this keeps it in flops rather than a RAM macro, which is fine at 32 entries.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        // NOTE: state is always updated with non-blocking assignments so every reader sees
        // the pre-edge value regardless of process evaluation order.
        regs[i] <= '0;
      end
    end else if (wr_valid) begin
      regs[rf.waddr_i] <= rf.wdata_i;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] raddr);
    logic [DATA_W-1:0] data;
    data = '0;
    if (!rst) begin
      data = '0;
    end else if (raddr == '0) begin
      data = '0;
    end else if (BYPASS && wr_valid && (raddr == rf.waddr_i)) begin
      data = rf.wdata_i;
    end else begin
      data = regs[raddr];
    end
    return data;
  endfunction

  // NOTE: combinational outputs get a default before any branch so no latch is inferred.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    rdata1 = read_port(rf.raddr1_i);
    rdata2 = read_port(rf.raddr2_i);
  end

  assign rf.rdata1_o = rdata1;
  assign rf.rdata2_o = rdata2;

endmodule

// File: tb/tb_rv32_regfile.sv
// Directed bench for rv32_regfile: one forwarding and one non-forwarding instance driven
// with identical stimulus, compared against hand-computed values.
module tb_rv32_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  rv32_regfile_if #(.DATA_W(32), .ADDR_W(5)) rf_byp ();
  rv32_regfile_if #(.DATA_W(32), .ADDR_W(5)) rf_nob ();

  assign rf_byp.we_i     = we;
  assign rf_byp.waddr_i  = waddr;
  assign rf_byp.wdata_i  = wdata;
  assign rf_byp.raddr1_i = raddr1;
  assign rf_byp.raddr2_i = raddr2;
  assign rf_nob.we_i     = we;
  assign rf_nob.waddr_i  = waddr;
  assign rf_nob.wdata_i  = wdata;
  assign rf_nob.raddr1_i = raddr1;
  assign rf_nob.raddr2_i = raddr2;

  rv32_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u_byp (
    .clk (clk),
    .rst (rst),
    .rf  (rf_byp.slave)
  );

  rv32_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u_nob (
    .clk (clk),
    .rst (rst),
    .rf  (rf_nob.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    we     = w;
    waddr  = wa;
    wdata  = wd;
    raddr1 = r1;
    raddr2 = r2;
  endtask

  // Single write: inputs set at the falling edge, committed on the next rising edge.
  task automatic write_reg(input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    drive(1'b1, wa, wd, 5'd0, 5'd0);
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    // Reset held for two edges while a write is attempted; outputs forced to zero.
    rst = 1'b0;
    drive(1'b1, 5'd7, 32'h5555_aaaa, 5'd7, 5'd7);
    #1;
    check("rst_rd1_byp", rf_byp.rdata1_o, 32'h0);
    check("rst_rd2_nob", rf_nob.rdata2_o, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    we  = 1'b0;

    for (int i = 1; i < 32; i++) begin
      if (i > 1) @(negedge clk);
      raddr1 = 5'(i);
      raddr2 = 5'(32 - i);
      #1;
      check($sformatf("clr_rd1_x%0d", i), rf_byp.rdata1_o, 32'h0);
      check($sformatf("clr_rd2_x%0d", 32 - i), rf_nob.rdata2_o, 32'h0);
    end

    // Write x1 then hold it across several idle cycles.
    write_reg(5'd1, 32'h0fff_1000);
    raddr1 = 5'd1;
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("hold_x1_c%0d", c), rf_byp.rdata1_o, 32'h0fff_1000);
      check($sformatf("hold_x1_nob_c%0d", c), rf_nob.rdata1_o, 32'h0fff_1000);
      @(negedge clk);
    end

    // Write to x0 is ignored, including by the bypass path.
    drive(1'b1, 5'd0, 32'hdead_beef, 5'd0, 5'd0);
    #1;
    check("x0_pre_byp", rf_byp.rdata1_o, 32'h0);
    check("x0_pre_nob", rf_nob.rdata1_o, 32'h0);
    @(negedge clk);
    we = 1'b0;
    #1;
    check("x0_post_byp", rf_byp.rdata1_o, 32'h0);
    check("x0_post_nob", rf_nob.rdata1_o, 32'h0);

    // Forwarding: x5 preloaded so the non-forwarding instance shows a distinct old value.
    write_reg(5'd5, 32'h1111_1111);
    drive(1'b1, 5'd5, 32'h1234_5678, 5'd6, 5'd5);
    #1;
    check("byp_rd2_hit", rf_byp.rdata2_o, 32'h1234_5678);
    check("nob_rd2_old", rf_nob.rdata2_o, 32'h1111_1111);
    check("byp_rd1_miss", rf_byp.rdata1_o, 32'h0);
    raddr1 = 5'd5;
    #1;
    check("byp_rd1_hit", rf_byp.rdata1_o, 32'h1234_5678);
    check("nob_rd1_old", rf_nob.rdata1_o, 32'h1111_1111);
    @(negedge clk);
    we = 1'b0;
    #1;
    check("byp_rd2_new", rf_byp.rdata2_o, 32'h1234_5678);
    check("nob_rd2_new", rf_nob.rdata2_o, 32'h1234_5678);

    // Concurrent reads of two different registers, then both ports on the same one.
    write_reg(5'd31, 32'hffff_ffff);
    write_reg(5'd2, 32'h0000_0002);
    raddr1 = 5'd31;
    raddr2 = 5'd2;
    #1;
    check("dual_rd1_x31", rf_byp.rdata1_o, 32'hffff_ffff);
    check("dual_rd2_x2", rf_byp.rdata2_o, 32'h0000_0002);
    raddr2 = 5'd31;
    #1;
    check("same_rd1_x31", rf_nob.rdata1_o, 32'hffff_ffff);
    check("same_rd2_x31", rf_nob.rdata2_o, 32'hffff_ffff);

    // Reset beats a concurrent write; outputs forced low while reset is asserted.
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 5'd3, 32'h0000_00aa, 5'd1, 5'd3);
    #1;
    check("rst_force_rd1", rf_byp.rdata1_o, 32'h0);
    check("rst_force_rd2", rf_byp.rdata2_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    we  = 1'b0;
    #1;
    check("rst2_x1_byp", rf_byp.rdata1_o, 32'h0);
    check("rst2_x3_byp", rf_byp.rdata2_o, 32'h0);
    check("rst2_x1_nob", rf_nob.rdata1_o, 32'h0);
    check("rst2_x3_nob", rf_nob.rdata2_o, 32'h0);
    raddr1 = 5'd31;
    #1;
    check("rst2_x31", rf_byp.rdata1_o, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
